// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: one shared memory port with a req/ready handshake,
// and a control FSM that sequences each instruction.
module mips_multicycle_core #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          TEST_WIDTH = 16,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk_top,
  input  logic                  reset_top,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [TEST_WIDTH-1:0] test_value_top,
  output logic                  illegal_top,
  output logic [3:0]            state_top
);
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

  logic [3:0]            state, state_nx;
  logic [31:0]           pc, ir, mdr, a, b, alu_out, alu_res, imm_sx, addr_full;
  logic [31:0][31:0]     regs;
  logic [TEST_WIDTH-1:0] test_val;
  logic [5:0]            op, funct;
  logic [4:0]            rs, rt, rd;
  logic                  r_ok, unused_shamt;

  assign op           = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign unused_shamt = ^ir[10:6];
  assign imm_sx       = {{16{ir[15]}}, ir[15:0]};
  assign r_ok         = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                        (funct == 6'h25) || (funct == 6'h2A);

  // Request is gated by reset so it drops immediately, even mid-transaction.
  assign mem_req        = reset_top && ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
  assign mem_we         = reset_top && (state == S_MEMWR);
  assign addr_full      = (state == S_FETCH) ? pc : alu_out;
  assign mem_addr       = addr_full[ADDR_WIDTH-1:0];
  assign mem_wdata      = b;
  assign test_value_top = test_val;
  assign illegal_top    = (state == S_ILLEGAL);
  assign state_top      = state;

  always_comb begin
    alu_res = 32'h0;
    case (funct)
      6'h20:   alu_res = a + b;
      6'h22:   alu_res = a - b;
      6'h24:   alu_res = a & b;
      6'h25:   alu_res = a | b;
      6'h2A:   alu_res = {31'h0, $signed(a) < $signed(b)};
      default: alu_res = 32'h0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_R:         state_nx = r_ok ? S_EXEC : S_ILLEGAL;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JUMP;
          default:      state_nx = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
      S_EXEC:   state_nx = S_ALUWB;
      S_ADDIEX: state_nx = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_nx = S_FETCH;
      S_ILLEGAL: state_nx = S_ILLEGAL;
      default:   state_nx = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk_top or negedge reset_top) begin
    if (!reset_top) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      mdr      <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      regs     <= '0;
      test_val <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        S_DECODE: begin
          a       <= regs[rs];
          b       <= regs[rt];
          alu_out <= pc + (imm_sx << 2);
        end
        S_MEMADR, S_ADDIEX: alu_out <= a + imm_sx;
        S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        S_MEMWR:  if (mem_ready) test_val <= b[TEST_WIDTH-1:0];
        S_EXEC:   alu_out <= alu_res;
        S_BRANCH: if (a == b) pc <= alu_out;
        S_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        // Register 0 is never written, so it always reads back as zero.
        S_MEMWB:  if (rt != 5'd0) regs[rt] <= mdr;
        S_ALUWB:  if (rd != 5'd0) regs[rd] <= alu_out;
        S_ADDIWB: if (rt != 5'd0) regs[rt] <= alu_out;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS top. It shares one memory port between instruction fetch and data access, and sequences each instruction through a control FSM. The register file, ALU, PC, IR/MDR/A/B/ALUOut holding registers and the main FSM are all internal. Memory is external behind a req/ready handshake, so the core tolerates wait states. It sits as the processor top, replacing the separate instruction/data memories with one unified memory.

Parameters:
ADDR_WIDTH, 32, width of mem_addr; it carries the low ADDR_WIDTH bits of the byte address (8..32).
TEST_WIDTH, 16, width of test_value_top (1..32).
RESET_PC, 0, PC value loaded on reset; must be word aligned.

Ports:
clk_top  in  1  core clock, rising edge.
reset_top  in  1  asynchronous, active-low reset.
mem_req  out  1  memory transaction request.
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
mem_addr  out  ADDR_WIDTH  byte address; word aligned.
mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1.
mem_rdata  in  32  read data; sampled on the edge where mem_req=1 and mem_ready=1.
mem_ready  in  1  completes the current transaction at a clock edge.
test_value_top  out  TEST_WIDTH  low TEST_WIDTH bits of the most recent sw data.
illegal_top  out  1  sticky flag: unsupported opcode/funct decoded.
state_top  out  4  current FSM state encoding, for debug.

Behaviour:
- Reset (reset_top=0, async):
  - state=FETCH, PC=RESET_PC.
  - All 32 registers, IR, MDR, A, B and ALUOut = 0.
  - test_value_top=0, illegal_top=0.
  - Outputs are decoded from the state, so mem_req drops in the same cycle reset asserts, including mid-transaction. Any pending memory access is abandoned.
- ISA: lw, sw, beq, addi, j, and R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex).
  - Any other opcode, or an unlisted R funct, goes to state ILLEGAL: sticky, illegal_top=1, no further memory traffic until reset.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ready: IR<=rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm)<<2).
    - lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; addi -> ADDIEX; j -> JUMP; else -> ILLEGAL.
  - MEMADR: ALUOut<=A+sext(imm). lw -> MEMRD; sw -> MEMWR.
  - MEMRD: mem_req=1, mem_we=0, mem_addr=ALUOut. On ready: MDR<=rdata, go to MEMWB.
  - MEMWB: R[rt]<=MDR, go to FETCH.
  - MEMWR: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B. On ready: test_value_top<=B[TEST_WIDTH-1:0], go to FETCH.
  - EXEC: ALUOut<=A op B, go to ALUWB.
  - ALUWB: R[rd]<=ALUOut, go to FETCH.
  - BRANCH: if A==B then PC<=ALUOut; go to FETCH.
  - ADDIEX: ALUOut<=A+sext(imm), go to ADDIWB.
  - ADDIWB: R[rt]<=ALUOut, go to FETCH.
  - JUMP: PC<={PC[31:28],IR[25:0],2'b00}, go to FETCH.
- Memory handshake:
  - While mem_ready=0, the state, mem_req, mem_we, mem_addr and mem_wdata are held unchanged. Any number of wait cycles is allowed.
  - Exactly one transaction completes per edge with mem_req=mem_ready=1.
  - mem_ready outside a request is ignored.
- Latency (zero wait states): beq and j take 3 cycles; R-type, addi and sw take 4; lw takes 5. Each wait cycle adds 1.
- Arithmetic:
  - All operations are 32-bit, two's-complement wrap, overflow ignored.
  - slt is signed and writes 1 or 0.
  - sext means sign-extend the 16-bit immediate to 32 bits.
  - PC arithmetic wraps at 2^32.
  - mem_addr = low ADDR_WIDTH bits of the internal 32-bit address.
- Register 0 always reads 0; writes to it are discarded.
- A beq whose target equals its own address loops forever; this is a legal halt idiom.

Test Plan:
1. Reset, mem_ready tied 1, program "addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x40($0)" -> the write transaction has mem_addr=0x40 and mem_wdata=12, test_value_top=0x000C, and the write occurs on cycle 16.
2. lw with 3 wait cycles on each transaction (memory[0x40]=0xDEADBEEF) -> R[rt]=0xDEADBEEF; mem_addr and mem_req are stable during the waits; total 11 cycles.
3. "addi $1,$0,-1; slt $2,$1,$0; beq $2,$2,-1" -> R2=1, then fetches repeat at the beq address forever.
4. j 0x0000010 issued from PC=0x8 -> the next fetch address is 0x40; "addi $0,$0,9" followed by "sw $0,0" stores 0.
5. Opcode 0x3F fetched -> illegal_top=1 from the cycle after DECODE; mem_req stays 0 thereafter; reset_top low clears it.
6. reset_top asserted low during a MEMWR wait state -> mem_req=0 the same cycle, no write occurs, test_value_top=0, and the first fetch after release is at RESET_PC.
